// File: rtl/cr_huf_comp_seq_id_ctx_table_pkg.sv
// Shared constants, width helper and context-word layout for the Huffman
// compressor sequence-ID context table.
package cr_huf_compPKG;

  localparam int CREOLE_HC_SEQID_NUM = 16;
  localparam int CREOLE_HC_DATA_W    = 64;
  localparam int CREOLE_HC_CRC_W     = 32;
  localparam int CREOLE_HC_N_RD      = 12;

  function automatic int seqid_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // CRC field sits in the least significant bits of the context word
  typedef struct packed {
    logic [CREOLE_HC_DATA_W-CREOLE_HC_CRC_W-1:0] upper;
    logic [CREOLE_HC_CRC_W-1:0]                  crc;
  } ctx_word_t;

endpackage

// File: rtl/cr_huf_comp_seq_id_ctx_table_rr_free_find.sv
// Circular first-zero search over the valid bitmap, starting at start and
// wrapping SEQID_NUM-1 -> 0.
module cr_huf_comp_rr_free_find
  import cr_huf_compPKG::*;
#(
  parameter  int SEQID_NUM = CREOLE_HC_SEQID_NUM,
  localparam int SEQID_W   = seqid_width(SEQID_NUM)
) (
  input  logic [SEQID_NUM-1:0] vld,
  input  logic [SEQID_W-1:0]   start,
  output logic                 found,
  output logic [SEQID_W-1:0]   idx
);

  always_comb begin
    int j;
    logic [SEQID_W-1:0] jj;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int i = 0; i < SEQID_NUM; i++) begin
      j = int'(start) + i;
      if (j >= SEQID_NUM) j = j - SEQID_NUM;
      jj = SEQID_W'(j);
      if (!found && !vld[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/cr_huf_comp_seq_id_ctx_table.sv
// Per-sequence-ID context table: round-robin ID allocation, full/CRC-field
// writes, release, and N_RD registered lookup ports over a flop array.
module cr_huf_comp_seq_id_ctx_table
  import cr_huf_compPKG::*;
#(
  parameter  int SEQID_NUM = CREOLE_HC_SEQID_NUM,
  parameter  int DATA_W    = CREOLE_HC_DATA_W,
  parameter  int CRC_W     = CREOLE_HC_CRC_W,
  parameter  int N_RD      = CREOLE_HC_N_RD,
  localparam int SEQID_W   = seqid_width(SEQID_NUM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc_req,
  output logic                      alloc_rdy,
  output logic [SEQID_W-1:0]        alloc_id,
  input  logic                      wr_vld,
  input  logic [SEQID_W-1:0]        wr_id,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      crc_vld,
  input  logic [SEQID_W-1:0]        crc_id,
  input  logic [CRC_W-1:0]          crc_data,
  input  logic                      rel_vld,
  input  logic [SEQID_W-1:0]        rel_id,
  input  logic [N_RD*SEQID_W-1:0]   rd_id,
  output logic [N_RD*DATA_W-1:0]    rd_data,
  output logic [N_RD-1:0]           rd_hit,
  output logic [SEQID_NUM-1:0]      vld_vec,
  output logic [SEQID_W:0]          occupancy,
  output logic                      full,
  output logic                      empty,
  output logic                      err_wr_unalloc,
  output logic                      err_rel_unalloc
);

  localparam int IDX_SPAN = 1 << SEQID_W;

  logic [SEQID_NUM-1:0] vld_q, vld_d;
  logic [IDX_SPAN-1:0]  vld_ext, in_rng;
  logic [DATA_W-1:0]    ctx_q [SEQID_NUM];
  logic [SEQID_W:0]     occ_q, occ_d;
  logic [SEQID_W-1:0]   last_ptr_q, last_ptr_d, alloc_id_q, alloc_id_d;
  logic [SEQID_W-1:0]   search_start, free_idx;
  logic                 free_found, grant, wr_ok, crc_ok, rel_ok;
  logic                 err_wr_q, err_rel_q;

  // Padding to the full index span makes out-of-range IDs read as unallocated
  always_comb begin
    vld_ext = '0;
    vld_ext[SEQID_NUM-1:0] = vld_q;
    in_rng = '0;
    in_rng[SEQID_NUM-1:0] = '1;
  end

  assign grant  = alloc_req & alloc_rdy;
  assign wr_ok  = wr_vld  & vld_ext[wr_id];
  assign crc_ok = crc_vld & vld_ext[crc_id];
  assign rel_ok = rel_vld & vld_ext[rel_id];

  always_comb begin
    vld_d = vld_q;
    if (grant)  vld_d[alloc_id_q] = 1'b1;
    if (rel_ok) vld_d[rel_id]     = 1'b0;
    occ_d = occ_q;
    if (grant && !rel_ok)      occ_d = occ_q + (SEQID_W+1)'(1);
    else if (!grant && rel_ok) occ_d = occ_q - (SEQID_W+1)'(1);
    last_ptr_d   = grant ? alloc_id_q : last_ptr_q;
    search_start = (last_ptr_d == SEQID_W'(SEQID_NUM-1)) ? '0 : last_ptr_d + SEQID_W'(1);
    alloc_id_d   = free_found ? free_idx : alloc_id_q;
  end

  cr_huf_comp_rr_free_find #(.SEQID_NUM(SEQID_NUM)) u_free_find (
    .vld   (vld_d),
    .start (search_start),
    .found (free_found),
    .idx   (free_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      occ_q      <= '0;
      last_ptr_q <= SEQID_W'(SEQID_NUM-1);
      alloc_id_q <= '0;
      err_wr_q   <= 1'b0;
      err_rel_q  <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      occ_q      <= occ_d;
      last_ptr_q <= last_ptr_d;
      alloc_id_q <= alloc_id_d;
      err_wr_q   <= (wr_vld & ~wr_ok) | (crc_vld & ~crc_ok);
      err_rel_q  <= rel_vld & ~rel_ok;
    end
  end

  // CRC update follows the full write so it owns the low field on a collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SEQID_NUM; i++) ctx_q[i] <= '0;
    end else begin
      for (int i = 0; i < SEQID_NUM; i++) begin
        if (wr_ok && wr_id == SEQID_W'(i))   ctx_q[i]            <= wr_data;
        if (crc_ok && crc_id == SEQID_W'(i)) ctx_q[i][CRC_W-1:0] <= crc_data;
      end
    end
  end

  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    logic [SEQID_W-1:0] id;
    logic [DATA_W-1:0]  data_q;
    logic               hit_q;

    assign id = rd_id[p*SEQID_W +: SEQID_W];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        hit_q  <= 1'b0;
      end else begin
        data_q <= in_rng[id] ? ctx_q[id] : '0;
        hit_q  <= vld_ext[id];
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = data_q;
    assign rd_hit[p]                   = hit_q;
  end

  assign vld_vec         = vld_q;
  assign occupancy       = occ_q;
  assign full            = (occ_q == (SEQID_W+1)'(SEQID_NUM));
  assign empty           = (occ_q == '0);
  assign alloc_rdy       = ~full;
  assign alloc_id        = alloc_id_q;
  assign err_wr_unalloc  = err_wr_q;
  assign err_rel_unalloc = err_rel_q;

endmodule

// File: tb/tb_cr_huf_comp_seq_id_ctx_table.sv
// Scoreboard bench: driver pushes reference-model expectations per cycle,
// monitor pops and compares them against the registered DUT outputs.
module tb_cr_huf_comp_seq_id_ctx_table;

  localparam int N  = 16;
  localparam int DW = 64;
  localparam int CW = 32;
  localparam int NR = 12;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic alloc_req, alloc_rdy, wr_vld, crc_vld, rel_vld;
  logic [SW-1:0] alloc_id, wr_id, crc_id, rel_id;
  logic [DW-1:0] wr_data;
  logic [CW-1:0] crc_data;
  logic [NR*SW-1:0] rd_id;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0] rd_hit;
  logic [N-1:0] vld_vec;
  logic [SW:0] occupancy;
  logic full, empty, err_wr_unalloc, err_rel_unalloc;

  always #5 clk = ~clk;

  cr_huf_comp_seq_id_ctx_table dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_rdy(alloc_rdy), .alloc_id(alloc_id),
    .wr_vld(wr_vld), .wr_id(wr_id), .wr_data(wr_data),
    .crc_vld(crc_vld), .crc_id(crc_id), .crc_data(crc_data),
    .rel_vld(rel_vld), .rel_id(rel_id),
    .rd_id(rd_id), .rd_data(rd_data), .rd_hit(rd_hit),
    .vld_vec(vld_vec), .occupancy(occupancy), .full(full), .empty(empty),
    .err_wr_unalloc(err_wr_unalloc), .err_rel_unalloc(err_rel_unalloc)
  );

  typedef struct packed {
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_hit;
    logic             err_wr;
    logic             err_rel;
    logic [SW:0]      occ;
    logic [N-1:0]     vld;
    logic [SW-1:0]    alloc_id;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DW-1:0] m_ctx [N];
  bit            m_vld [N];
  int            m_last, m_alloc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_vld[i];
    return c;
  endfunction

  function automatic int model_next_free();
    for (int k = 1; k <= N; k++) begin
      int id = (m_last + k) % N;
      if (!m_vld[id]) return id;
    end
    return m_alloc;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_ctx[i] = '0;
      m_vld[i] = 1'b0;
    end
    m_last  = N - 1;
    m_alloc = 0;
  endtask

  task automatic idle();
    alloc_req = 0; wr_vld = 0; crc_vld = 0; rel_vld = 0;
    wr_id = '0; crc_id = '0; rel_id = '0; wr_data = '0; crc_data = '0;
    rd_id = '0;
  endtask

  task automatic set_all_rd(input int id);
    for (int p = 0; p < NR; p++) rd_id[p*SW +: SW] = SW'(id);
  endtask

  // Called at a negedge with inputs set; predicts the outputs after the next edge.
  task automatic cycle();
    exp_t e;
    bit grant, wok, cok, rok;
    int occ_now;
    e = '0;
    for (int p = 0; p < NR; p++) begin
      int id = int'(rd_id[p*SW +: SW]);
      e.rd_data[p*DW +: DW] = (id < N) ? m_ctx[id] : '0;
      e.rd_hit[p]           = (id < N) ? m_vld[id] : 1'b0;
    end
    occ_now = model_count();
    grant = alloc_req && (occ_now < N);
    wok = wr_vld  && (int'(wr_id)  < N) && m_vld[wr_id];
    cok = crc_vld && (int'(crc_id) < N) && m_vld[crc_id];
    rok = rel_vld && (int'(rel_id) < N) && m_vld[rel_id];
    e.err_wr  = (wr_vld && !wok) || (crc_vld && !cok);
    e.err_rel = rel_vld && !rok;
    if (wok) m_ctx[wr_id] = wr_data;
    if (cok) m_ctx[crc_id][CW-1:0] = crc_data;
    if (grant) begin
      m_vld[m_alloc] = 1'b1;
      m_last = m_alloc;
    end
    if (rok) m_vld[rel_id] = 1'b0;
    m_alloc = model_next_free();
    e.occ = (SW+1)'(model_count());
    for (int i = 0; i < N; i++) e.vld[i] = m_vld[i];
    e.alloc_id = SW'(m_alloc);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int p = 0; p < NR; p++)
          check($sformatf("rd_data[%0d]", p), rd_data[p*DW +: DW], e.rd_data[p*DW +: DW]);
        check("rd_hit", 64'(rd_hit), 64'(e.rd_hit));
        check("err_wr_unalloc", 64'(err_wr_unalloc), 64'(e.err_wr));
        check("err_rel_unalloc", 64'(err_rel_unalloc), 64'(e.err_rel));
        check("occupancy", 64'(occupancy), 64'(e.occ));
        check("vld_vec", 64'(vld_vec), 64'(e.vld));
        check("full", 64'(full), 64'(e.occ == (SW+1)'(N)));
        check("empty", 64'(empty), 64'(e.occ == '0));
        check("alloc_rdy", 64'(alloc_rdy), 64'(e.occ != (SW+1)'(N)));
        if (e.occ != (SW+1)'(N)) check("alloc_id", 64'(alloc_id), 64'(e.alloc_id));
      end
    end
  end

  initial begin : driver
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst occupancy", 64'(occupancy), 64'd0);
    check("rst empty", 64'(empty), 64'd1);
    check("rst full", 64'(full), 64'd0);
    check("rst alloc_rdy", 64'(alloc_rdy), 64'd1);
    check("rst alloc_id", 64'(alloc_id), 64'd0);
    check("rst vld_vec", 64'(vld_vec), 64'd0);
    check("rst rd_hit", 64'(rd_hit), 64'd0);
    check("rst rd_data0", rd_data[DW-1:0], 64'd0);
    check("rst err_wr", 64'(err_wr_unalloc), 64'd0);
    check("rst err_rel", 64'(err_rel_unalloc), 64'd0);
    rst_n = 1'b1;

    // fill all IDs, one more request back-pressured, then release 5 while full
    alloc_req = 1;
    repeat (17) cycle();
    rel_vld = 1; rel_id = 4'd5;
    cycle();
    rel_vld = 0;
    cycle();
    idle();
    cycle();

    // round-robin from last_ptr and wrap of the free search
    do_reset();
    alloc_req = 1;
    repeat (4) cycle();
    idle(); rel_vld = 1; rel_id = 4'd1;
    cycle();
    idle(); alloc_req = 1;
    repeat (12) cycle();
    idle();
    cycle();

    // same-cycle full write and CRC update on ID 2
    wr_vld = 1; wr_id = 4'd2; wr_data = 64'hAAAA_BBBB_CCCC_DDDD;
    crc_vld = 1; crc_id = 4'd2; crc_data = 32'h1234_5678;
    cycle();
    idle(); set_all_rd(2);
    cycle();

    // read-during-write on ID 7 across all ports
    set_all_rd(7);
    wr_vld = 1; wr_id = 4'd7; wr_data = 64'h0707_0707_F00D_CAFE;
    cycle();
    wr_vld = 0;
    cycle();

    // write/release of an unallocated ID
    idle(); rel_vld = 1; rel_id = 4'd9;
    cycle();
    idle(); wr_vld = 1; wr_id = 4'd9; wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
    rel_vld = 1; rel_id = 4'd9;
    cycle();
    idle(); set_all_rd(9);
    cycle();

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      alloc_req = ($urandom_range(0, 1) == 1);
      wr_vld    = ($urandom_range(0, 2) == 0);
      wr_id     = SW'($urandom_range(0, N-1));
      wr_data   = {$urandom, $urandom};
      crc_vld   = ($urandom_range(0, 3) == 0);
      crc_id    = ($urandom_range(0, 1) == 1) ? wr_id : SW'($urandom_range(0, N-1));
      crc_data  = $urandom;
      rel_vld   = ($urandom_range(0, 2) == 0);
      rel_id    = ($urandom_range(0, 3) == 0) ? wr_id : SW'($urandom_range(0, N-1));
      for (int p = 0; p < NR; p++) rd_id[p*SW +: SW] = SW'($urandom_range(0, N-1));
      cycle();
    end

    // asynchronous reset mid-operation
    alloc_req = 1;
    #2 rst_n = 1'b0;
    #1;
    check("async rst occupancy", 64'(occupancy), 64'd0);
    check("async rst vld_vec", 64'(vld_vec), 64'd0);
    check("async rst rd_hit", 64'(rd_hit), 64'd0);
    check("async rst alloc_id", 64'(alloc_id), 64'd0);
    check("async rst rd_data0", rd_data[DW-1:0], 64'd0);
    exp_q.delete();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
